impulse_gen: RTL and testbench

Parametrised multi-channel successor to the single-output impulse generator. Each channel produces either a periodic pulse train or a one-shot pulse, with run-time programmable period and high-width. Channels are independent and drive `principal`-style consumers (impulse inputs, LED strobes) in the same clock domain.

---
 rtl/impulse_gen.sv | 130 +++++++++++++
 tb/tb_impulse_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/impulse_gen.sv
// Multi-channel impulse generator: each channel emits a periodic train or a one-shot pulse.
// Latency: first pulse cycle follows the edge that samples the start; all outputs registered.
// Backpressure: none; free-running per channel, and inputs are sampled every cycle.
module impulse_gen #(
    parameter int NCHAN  = 4,
    parameter int CNT_W  = 16,
    parameter int RETRIG = 0
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [NCHAN-1:0]       enable,
    input  logic [NCHAN-1:0]       mode,
    input  logic [NCHAN-1:0]       trigger,
    input  logic [NCHAN*CNT_W-1:0] period,
    input  logic [NCHAN*CNT_W-1:0] width,
    output logic [NCHAN-1:0]       impulse,
    output logic [NCHAN-1:0]       busy,
    output logic [NCHAN-1:0]       done,
    output logic [NCHAN-1:0]       err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    for (genvar g = 0; g < NCHAN; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_phase;
        logic [CNT_W-1:0] r_plat;
        logic [CNT_W-1:0] r_wlat;
        logic [CNT_W-1:0] w_phase_nxt;
        logic [CNT_W-1:0] w_plat_nxt;
        logic [CNT_W-1:0] w_wlat_nxt;
        logic [CNT_W-1:0] w_period;
        logic [CNT_W-1:0] w_width;
        logic [CNT_W-1:0] w_wmin;
        logic             r_imp;
        logic             r_done;
        logic             r_err;
        logic             w_done_nxt;
        logic             w_err_nxt;
        logic             w_last;
        logic             w_relatch;

        assign w_period = period[g*CNT_W +: CNT_W];
        assign w_width  = width[g*CNT_W +: CNT_W];
        // A width longer than the period just means "high for the whole period".
        assign w_wmin   = (w_width > w_period) ? w_period : w_width;
        assign w_last   = (r_phase == (r_plat - CNT_W'(1)));

        // Next-state: decide whether to (re)start, advance the phase, or drop to IDLE.
        always_comb begin
            w_state_nxt = r_state;
            w_phase_nxt = r_phase;
            w_plat_nxt  = r_plat;
            w_wlat_nxt  = r_wlat;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_relatch   = 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable[g] && (!mode[g] || trigger[g])) begin
                        w_relatch = 1'b1;
                    end
                end
                S_RUN: begin
                    if ((RETRIG != 0) && mode[g] && trigger[g]) begin
                        // Retrigger restarts at phase 0; a pending done is dropped.
                        w_relatch = 1'b1;
                    end else if (w_last) begin
                        if (!mode[g] && enable[g]) begin
                            w_relatch = 1'b1;
                        end else begin
                            // One-shot completion strobes done; disabled periodic just stops.
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = mode[g];
                        end
                    end else begin
                        w_phase_nxt = r_phase + CNT_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase

            // Common start/re-latch path; a zero period can never run.
            if (w_relatch) begin
                w_phase_nxt = '0;
                if (w_period == '0) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                    w_plat_nxt  = w_period;
                    w_wlat_nxt  = w_wmin;
                end
            end
        end

        // State and registered outputs; impulse is computed from the next phase so it
        // appears in the first cycle after the start edge.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                r_state <= S_IDLE;
                r_phase <= '0;
                r_plat  <= '0;
                r_wlat  <= '0;
                r_imp   <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_phase <= w_phase_nxt;
                r_plat  <= w_plat_nxt;
                r_wlat  <= w_wlat_nxt;
                r_imp   <= (w_state_nxt == S_RUN) && (w_phase_nxt < w_wlat_nxt);
                r_done  <= w_done_nxt;
                r_err   <= w_err_nxt;
            end
        end

        assign impulse[g] = r_imp;
        assign busy[g]    = (r_state == S_RUN);
        assign done[g]    = r_done;
        assign err[g]     = r_err;
    end

endmodule

// File: tb/tb_impulse_gen.sv
// Directed bench for impulse_gen: two instances share stimulus, one built with RETRIG=1.
// Inputs are driven 1 time unit after each rising edge and outputs are checked there.
// Expected values are hand-derived from the behavioural description of each scenario.
module tb_impulse_gen;

    localparam int NCHAN = 4;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   nrst;
    logic [NCHAN-1:0]       enable;
    logic [NCHAN-1:0]       mode;
    logic [NCHAN-1:0]       trigger;
    logic [NCHAN*CNT_W-1:0] period;
    logic [NCHAN*CNT_W-1:0] width;
    logic [NCHAN-1:0]       imp_a, busy_a, done_a, err_a;
    logic [NCHAN-1:0]       imp_b, busy_b, done_b, err_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    impulse_gen #(.NCHAN(NCHAN), .CNT_W(CNT_W), .RETRIG(0)) u_dut (
        .clk(clk), .nrst(nrst), .enable(enable), .mode(mode), .trigger(trigger),
        .period(period), .width(width),
        .impulse(imp_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    impulse_gen #(.NCHAN(NCHAN), .CNT_W(CNT_W), .RETRIG(1)) u_dut_rt (
        .clk(clk), .nrst(nrst), .enable(enable), .mode(mode), .trigger(trigger),
        .period(period), .width(width),
        .impulse(imp_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic en, input logic md,
                          input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] w);
        enable[ch]              = en;
        mode[ch]                = md;
        period[ch*CNT_W +: CNT_W] = p;
        width[ch*CNT_W +: CNT_W]  = w;
    endtask

    task automatic do_reset();
        enable  = '0;
        mode    = '0;
        trigger = '0;
        period  = '0;
        width   = '0;
        nrst    = 1'b0;
        step();
        nrst    = 1'b1;
    endtask

    int hi_a, hi_b, dn_a, dn_b;

    initial begin
        // Reset dominates even with every channel asking to start.
        nrst    = 1'b0;
        enable  = '1;
        mode    = '0;
        trigger = '1;
        period  = {NCHAN{16'd3}};
        width   = {NCHAN{16'd1}};
        step();
        check_eq("rst_impulse", 32'(imp_a), 32'h0);
        check_eq("rst_busy",    32'(busy_a), 32'h0);
        check_eq("rst_done",    32'(done_a), 32'h0);
        check_eq("rst_err",     32'(err_a), 32'h0);
        check_eq("rst_rt_busy", 32'(busy_b), 32'h0);

        // Periodic P=5 W=2 on ch0: 1,1,0,0,0 repeating.
        do_reset();
        set_ch(0, 1'b1, 1'b0, 16'd5, 16'd2);
        step();
        for (int c = 0; c < 10; c++) begin
            check_eq($sformatf("t1_imp_c%0d", c), 32'(imp_a[0]), ((c % 5) < 2) ? 32'h1 : 32'h0);
            check_eq($sformatf("t1_busy_c%0d", c), 32'(busy_a[0]), 32'h1);
            step();
        end

        // One-shot P=4 W=3 on ch1 with a single-cycle trigger.
        do_reset();
        set_ch(1, 1'b1, 1'b1, 16'd4, 16'd3);
        trigger[1] = 1'b1;
        step();
        trigger[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("t2_imp_c%0d", c), 32'(imp_a[1]), (c < 3) ? 32'h1 : 32'h0);
            check_eq($sformatf("t2_busy_c%0d", c), 32'(busy_a[1]), 32'h1);
            check_eq($sformatf("t2_done_c%0d", c), 32'(done_a[1]), 32'h0);
            step();
        end
        check_eq("t2_done_strobe", 32'(done_a[1]), 32'h1);
        check_eq("t2_idle_busy",   32'(busy_a[1]), 32'h0);
        check_eq("t2_idle_imp",    32'(imp_a[1]), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq($sformatf("t2_after_done_c%0d", c), 32'(done_a[1]), 32'h0);
            check_eq($sformatf("t2_after_imp_c%0d", c), 32'(imp_a[1]), 32'h0);
            check_eq($sformatf("t2_after_busy_c%0d", c), 32'(busy_a[1]), 32'h0);
        end

        // ch2 P=6 W=6, enable dropped at phase 2: the period still completes.
        do_reset();
        set_ch(2, 1'b1, 1'b0, 16'd6, 16'd6);
        step();
        for (int c = 0; c < 6; c++) begin
            check_eq($sformatf("t3_imp_c%0d", c), 32'(imp_a[2]), 32'h1);
            check_eq($sformatf("t3_busy_c%0d", c), 32'(busy_a[2]), 32'h1);
            if (c == 2) enable[2] = 1'b0;
            step();
        end
        check_eq("t3_end_imp",  32'(imp_a[2]), 32'h0);
        check_eq("t3_end_busy", 32'(busy_a[2]), 32'h0);
        // Same with W=0: busy cycles, impulse never rises.
        set_ch(2, 1'b1, 1'b0, 16'd6, 16'd0);
        step();
        for (int c = 0; c < 6; c++) begin
            check_eq($sformatf("t3w0_imp_c%0d", c), 32'(imp_a[2]), 32'h0);
            check_eq($sformatf("t3w0_busy_c%0d", c), 32'(busy_a[2]), 32'h1);
            if (c == 3) enable[2] = 1'b0;
            step();
        end
        check_eq("t3w0_end_busy", 32'(busy_a[2]), 32'h0);

        // ch3 start with period 0, then a periodic run whose period goes to 0.
        do_reset();
        set_ch(3, 1'b1, 1'b0, 16'd0, 16'd1);
        step();
        enable[3] = 1'b0;
        check_eq("t4_err",      32'(err_a[3]), 32'h1);
        check_eq("t4_err_busy", 32'(busy_a[3]), 32'h0);
        check_eq("t4_err_imp",  32'(imp_a[3]), 32'h0);
        step();
        check_eq("t4_err_clear", 32'(err_a[3]), 32'h0);
        set_ch(3, 1'b1, 1'b0, 16'd5, 16'd1);
        step();
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("t4_run_busy_c%0d", c), 32'(busy_a[3]), 32'h1);
            check_eq($sformatf("t4_run_imp_c%0d", c), 32'(imp_a[3]), (c == 0) ? 32'h1 : 32'h0);
            check_eq($sformatf("t4_run_err_c%0d", c), 32'(err_a[3]), 32'h0);
            if (c == 2) period[3*CNT_W +: CNT_W] = 16'd0;
            step();
        end
        check_eq("t4_bnd_busy", 32'(busy_a[3]), 32'h0);
        check_eq("t4_bnd_err",  32'(err_a[3]), 32'h1);
        check_eq("t4_bnd_imp",  32'(imp_a[3]), 32'h0);
        enable[3] = 1'b0;
        step();
        check_eq("t4_bnd_err_clear", 32'(err_a[3]), 32'h0);

        // One-shot P=8 W=8 on ch1, second trigger after 5 high cycles.
        do_reset();
        set_ch(1, 1'b1, 1'b1, 16'd8, 16'd8);
        trigger[1] = 1'b1;
        step();
        trigger[1] = 1'b0;
        hi_a = 0; hi_b = 0; dn_a = 0; dn_b = 0;
        for (int c = 0; c < 20; c++) begin
            if (imp_a[1])  hi_a++;
            if (imp_b[1])  hi_b++;
            if (done_a[1]) dn_a++;
            if (done_b[1]) dn_b++;
            trigger[1] = (c == 4);
            step();
        end
        check_eq("t5_noretrig_high", 32'(hi_a), 32'd8);
        check_eq("t5_noretrig_done", 32'(dn_a), 32'd1);
        check_eq("t5_retrig_high",   32'(hi_b), 32'd13);
        check_eq("t5_retrig_done",   32'(dn_b), 32'd1);

        // Reset pulse mid-pulse on all channels, then periodic restart at phase 0.
        do_reset();
        for (int ch = 0; ch < NCHAN; ch++) set_ch(ch, 1'b1, 1'b0, 16'd4, 16'd2);
        step();
        check_eq("t6_pre_imp", 32'(imp_a), 32'hf);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        check_eq("t6_rst_imp",  32'(imp_a), 32'h0);
        check_eq("t6_rst_busy", 32'(busy_a), 32'h0);
        check_eq("t6_rst_rt_imp", 32'(imp_b), 32'h0);
        step();
        check_eq("t6_ph0_imp",  32'(imp_a), 32'hf);
        check_eq("t6_ph0_busy", 32'(busy_a), 32'hf);
        step();
        check_eq("t6_ph1_imp",  32'(imp_a), 32'hf);
        step();
        check_eq("t6_ph2_imp",  32'(imp_a), 32'h0);
        check_eq("t6_ph2_busy", 32'(busy_a), 32'hf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
